reg_file_sb: RTL
================

Name: reg_file_sb

Overview:
- Parametrised successor to the core register file: XLEN-bit entries, NREG entries, NRD combinational read ports and one write port.
- Entry 0 is hardwired to zero.
- A per-entry busy scoreboard tracks registers with an in-flight producer (e.g. outstanding loads). Decode reads operand data and busy flags in the same cycle.
- After reset, a post-reset clear sweep zeroes storage, so the array can map to RAM without a reset.

Parameters:
- XLEN, 32: entry data width.
- NREG, 32: number of entries; power of two, at least 4.
- AW, 5: address width; must equal log2(NREG).
- NRD, 2: number of read ports, 1 to 4.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- rst, input, 1: asynchronous active-low reset.
- ready, output, 1: high when the clear sweep is done and the block accepts writes and issues.
- wr_en, input, 1: active-high write strobe.
- wr_addr, input, AW: write index.
- wr_data, input, XLEN: write data.
- iss_en, input, 1: issue strobe; marks iss_rd busy.
- iss_rd, input, AW: destination being issued.
- rs_addr, input, NRD*AW: read indices; port i occupies bits [i*AW +: AW].
- rs_data, output, NRD*XLEN: read data; port i occupies bits [i*XLEN +: XLEN].
- rs_busy, output, NRD: busy flag for each read port.
- busy_cnt, output, AW: number of entries currently busy (at most NREG-1).

Behaviour:
- Reset (rst=0, asynchronous):
  - FSM goes to INIT; sweep index set to 1.
  - Scoreboard cleared; busy_cnt=0; ready=0.
  - Storage contents are not reset.
  - Takes effect immediately, even mid-sweep or mid-operation.
- FSM states: INIT and RUN.
  - INIT: each cycle write 0 to entry[idx], then idx++.
  - When idx==NREG-1 is written, go to RUN on that edge.
  - With NREG=32: 31 INIT cycles; ready rises on the 31st rising edge after rst deasserts.
  - In INIT: wr_en and iss_en are ignored; rs_data forced to 0; rs_busy forced to 0.
  - RUN: stays in RUN until the next reset.
- Write (RUN, wr_en=1, wr_addr!=0):
  - entry[wr_addr] updated at the edge.
  - Scoreboard bit for wr_addr cleared.
  - A write to address 0 is dropped entirely.
- Issue (RUN, iss_en=1, iss_rd!=0):
  - Scoreboard bit for iss_rd set at the edge.
  - Issue to address 0 is ignored; entry 0 is never busy.
- Simultaneous write and issue to the same nonzero address: data is written and the bit ends SET (new producer wins); busy_cnt unchanged if the bit was already set.
- Issue to an already-busy entry: bit stays set; busy_cnt unchanged.
- Write to a non-busy entry: busy_cnt unchanged.
- busy_cnt: always equals the popcount of the scoreboard.
  - Increment or decrement on each 0->1 or 1->0 bit transition.
  - Net change per cycle is within -1..+1.
  - Never wraps.
- Reads are combinational:
  - rs_data[i] = entry[rs_addr[i]], or 0 if rs_addr[i]==0.
  - rs_busy[i] = scoreboard[rs_addr[i]].
  - Multiple ports may read the same address.

Optional Feature:
- Macro: RF_BYPASS_EN.
- Defined (write-through forwarding), applies in RUN only:
  - If wr_en=1, wr_addr==rs_addr[i] and rs_addr[i]!=0: rs_data[i]=wr_data in the same cycle.
  - In the same case rs_busy[i]=0, unless iss_en=1 with iss_rd==rs_addr[i] in that cycle, in which case rs_busy[i]=1.
- Not defined: reads return stored contents only; written data is visible from the cycle after the write edge; rs_busy reflects the registered scoreboard.

Test Plan:
- Reset/INIT: NREG=32, release rst, read r5 during INIT -> rs_data=0; ready=0 for 30 edges and 1 after the 31st edge; r1..r31 all read 0.
- Write/read: write r7=0xDEADBEEF, next cycle read r7 on port 0 and r0 on port 1 -> 0xDEADBEEF and 0x00000000. Write r0=0x1234 -> r0 still reads 0.
- Scoreboard:
  - Issue r3 then r9 -> busy_cnt=2, rs_busy set for both.
  - Write r3 -> rs_busy for r3 clears, busy_cnt=1.
  - Issue r3 and write r3 in the same cycle -> r3 busy, busy_cnt=2.
- Bypass: in the write cycle of r4=0x55, read r4.
  - With RF_BYPASS_EN: rs_data=0x55 and rs_busy=0 in that cycle.
  - Without: old value in that cycle, 0x55 the next cycle.
- Mid-operation reset: with busy_cnt=3, assert rst between edges -> ready, busy_cnt and rs_busy go to 0 immediately; full 31-cycle INIT repeats; previously written r7 reads 0 afterwards.
- Issue/write during INIT: strobe iss_en and wr_en to r2 at INIT cycle 10 -> no busy bit set; r2 reads 0 after ready.

Source files
------------

// File: rtl/reg_file_sb.sv
// Register file with a per-entry busy scoreboard and a post-reset clear sweep.
// Optional write-through forwarding on the read ports when RF_BYPASS_EN is defined.
module reg_file_sb #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5,
    parameter int NRD  = 2
) (
    input  logic                clk,
    input  logic                rst,
    output logic                ready,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_rd,
    input  logic [NRD*AW-1:0]   rs_addr,
    output logic [NRD*XLEN-1:0] rs_data,
    output logic [NRD-1:0]      rs_busy,
    output logic [AW-1:0]       busy_cnt
);

    typedef enum logic {INIT, RUN} state_t;

    state_t          state;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] mem [NREG];
    logic [NREG-1:0] sb;

    logic            wr_ok;
    logic            iss_ok;
    logic            cnt_inc;
    logic            cnt_dec;
    logic            mem_we;
    logic [AW-1:0]   mem_wa;
    logic [XLEN-1:0] mem_wd;

    always_comb begin
        wr_ok   = (state == RUN) && wr_en && (wr_addr != '0);
        iss_ok  = (state == RUN) && iss_en && (iss_rd != '0);
        // A same-address write+issue leaves the bit set, so it never counts as a clear.
        cnt_inc = iss_ok && !sb[iss_rd];
        cnt_dec = wr_ok && sb[wr_addr] && !(iss_ok && (iss_rd == wr_addr));
        mem_we  = (state == INIT) || wr_ok;
        mem_wa  = (state == INIT) ? idx : wr_addr;
        mem_wd  = (state == INIT) ? '0 : wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
            idx   <= AW'(1);
            ready <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    idx <= idx + AW'(1);
                    if (idx == AW'(NREG - 1)) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN:     state <= RUN;
                default: state <= INIT;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sb       <= '0;
            busy_cnt <= '0;
        end else begin
            if (wr_ok)
                sb[wr_addr] <= 1'b0;
            if (iss_ok)
                sb[iss_rd] <= 1'b1;
            if (cnt_inc && !cnt_dec)
                busy_cnt <= busy_cnt + AW'(1);
            else if (cnt_dec && !cnt_inc)
                busy_cnt <= busy_cnt - AW'(1);
        end
    end

    // Storage has no reset; the INIT sweep zeroes it instead.
    always_ff @(posedge clk) begin
        if (mem_we)
            mem[mem_wa] <= mem_wd;
    end

    always_comb begin
        rs_data = '0;
        rs_busy = '0;
        for (int unsigned i = 0; i < NRD; i++) begin
            if (state == RUN) begin
                if (rs_addr[i*AW +: AW] != '0)
                    rs_data[i*XLEN +: XLEN] = mem[rs_addr[i*AW +: AW]];
                rs_busy[i] = sb[rs_addr[i*AW +: AW]];
`ifdef RF_BYPASS_EN
                if (wr_ok && (wr_addr == rs_addr[i*AW +: AW])) begin
                    rs_data[i*XLEN +: XLEN] = wr_data;
                    rs_busy[i] = iss_ok && (iss_rd == rs_addr[i*AW +: AW]);
                end
`endif
            end
        end
    end

endmodule
